// File: rtl/saes_pkg.sv
// saes_pkg: shared constants and types for the Simplified-AES key expansion.
//   RCON1 / RCON2 : round constants for the two expansion steps
//   SBOX_TABLE    : 16-entry 4-bit S-box, entry i at bits [i*4 +: 4]
//   state_t       : key-expansion FSM state type
package saes_pkg;

    localparam logic [7:0] RCON1 = 8'h80;
    localparam logic [7:0] RCON2 = 8'h30;

    // Entry F in the top nibble down to entry 0 in the bottom nibble.
    localparam logic [63:0] SBOX_TABLE = 64'h7_F_E_C_3_0_2_6_5_8_1_D_B_A_4_9;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExp1 = 2'd1,
        StExp2 = 2'd2,
        StEmit = 2'd3
    } state_t;

endpackage

// File: rtl/saes_sub_nib.sv
// saes_sub_nib: combinational 4-bit S-box lookup.
//   i_nib [3:0] : input nibble
//   o_nib [3:0] : substituted nibble
module saes_sub_nib
    import saes_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    logic [5:0] w_base;

    assign w_base = {i_nib, 2'b00};
    assign o_nib  = SBOX_TABLE[w_base +: 4];

endmodule

// File: rtl/saes_key_expand.sv
// saes_key_expand: sequential S-AES key expansion and round-key streamer.
// Derives K0..K2 from a 16-bit key over two compute cycles, then emits one key
// per key_valid/key_ready handshake.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   start, key, encrypt  : expansion request, cipher key, direction (captured on start)
//   busy                 : high whenever not idle
//   key_valid, key_ready : round-key handshake
//   round_key, round_idx : current round key and its index (0..2)
//   done                 : one-cycle pulse after the third key is accepted
// Build option: define SAES_KEY_REVERSE_EN to honour encrypt=0 (emit K2, K1, K0);
// otherwise encrypt is ignored and emission is always forward.
module saes_key_expand
    import saes_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] key,
    input  logic        encrypt,
    output logic        busy,
    output logic        key_valid,
    input  logic        key_ready,
    output logic [15:0] round_key,
    output logic [1:0]  round_idx,
    output logic        done
);

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_w0, r_w1, r_w2, r_w3, r_w4, r_w5;
    logic [1:0] r_cnt;
    logic       r_done;
    logic       w_rev;

    logic       w_hs;
    logic       w_last;
    logic [7:0] w_sub_in;
    logic [7:0] w_g;
    logic [7:0] w_w2_next, w_w3_next, w_w4_next, w_w5_next;
    logic [1:0] w_idx;

    // One S-box pair shared by both expansion steps: w1 in EXP1, w3 in EXP2.
    // RotNib is folded in by feeding the low nibble to the high-output lookup.
    assign w_sub_in = (r_state == StExp2) ? r_w3 : r_w1;

    saes_sub_nib u_sub_hi (
        .i_nib (w_sub_in[3:0]),
        .o_nib (w_g[7:4])
    );

    saes_sub_nib u_sub_lo (
        .i_nib (w_sub_in[7:4]),
        .o_nib (w_g[3:0])
    );

    assign w_w2_next = r_w0 ^ RCON1 ^ w_g;
    assign w_w3_next = w_w2_next ^ r_w1;
    assign w_w4_next = r_w2 ^ RCON2 ^ w_g;
    assign w_w5_next = w_w4_next ^ r_w3;

    assign w_hs   = key_valid && key_ready;
    assign w_last = w_hs && (r_cnt == 2'd2);

`ifdef SAES_KEY_REVERSE_EN
    logic r_rev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rev <= 1'b0;
        end else if (r_state == StIdle && start) begin
            r_rev <= ~encrypt;
        end
    end

    assign w_rev = r_rev;
`else
    logic w_unused_encrypt;

    assign w_unused_encrypt = encrypt;
    assign w_rev            = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_next = StExp1;
            StExp1:  w_state_next = StExp2;
            StExp2:  w_state_next = StEmit;
            StEmit:  if (w_last) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= 2'd0;
            r_done  <= 1'b0;
            r_w0    <= 8'h00;
            r_w1    <= 8'h00;
            r_w2    <= 8'h00;
            r_w3    <= 8'h00;
            r_w4    <= 8'h00;
            r_w5    <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_last;
            if (r_state == StIdle && start) begin
                r_w0  <= key[15:8];
                r_w1  <= key[7:0];
                r_cnt <= 2'd0;
            end
            if (r_state == StExp1) begin
                r_w2 <= w_w2_next;
                r_w3 <= w_w3_next;
            end
            if (r_state == StExp2) begin
                r_w4 <= w_w4_next;
                r_w5 <= w_w5_next;
            end
            if (w_hs) begin
                r_cnt <= w_last ? 2'd0 : r_cnt + 2'd1;
            end
        end
    end

    assign busy      = (r_state != StIdle);
    assign key_valid = (r_state == StEmit);
    assign done      = r_done;
    assign w_idx     = w_rev ? (2'd2 - r_cnt) : r_cnt;

    always_comb begin
        round_key = 16'h0000;
        round_idx = 2'd0;
        if (key_valid) begin
            round_idx = w_idx;
            unique case (w_idx)
                2'd0:    round_key = {r_w0, r_w1};
                2'd1:    round_key = {r_w2, r_w3};
                default: round_key = {r_w4, r_w5};
            endcase
        end
    end

endmodule

// File: tb/tb_saes_key_expand.sv
module tb_saes_key_expand;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] key;
    logic        encrypt;
    logic        busy;
    logic        key_valid;
    logic        key_ready;
    logic [15:0] round_key;
    logic [1:0]  round_idx;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    saes_key_expand dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key       (key),
        .encrypt   (encrypt),
        .busy      (busy),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .round_key (round_key),
        .round_idx (round_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: g(w) = RCON ^ SubNib(RotNib(w)), chained per the S-AES schedule.
    function automatic logic [7:0] g_fn(input logic [7:0] w, input logic [7:0] rc);
        logic [3:0] sb [0:15];
        sb = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
               4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};
        return rc ^ {sb[w[3:0]], sb[w[7:4]]};
    endfunction

    function automatic logic [15:0] model_key(input logic [15:0] k, input int r);
        logic [7:0] w [0:5];
        logic [7:0] rc [1:2];
        rc[1] = 8'h80;
        rc[2] = 8'h30;
        w[0]  = k[15:8];
        w[1]  = k[7:0];
        for (int i = 1; i <= 2; i++) begin
            w[2*i]   = w[2*i-2] ^ g_fn(w[2*i-1], rc[i]);
            w[2*i+1] = w[2*i] ^ w[2*i-1];
        end
        return {w[2*r], w[2*r+1]};
    endfunction

    // mode: 0 = key_ready always 1, 1 = random key_ready, 2 = 3-cycle stall on K1.
    task automatic run_seq(input logic [15:0] k, input bit enc, input int mode, input bit glitch);
        logic [15:0] exp_key [$];
        logic [1:0]  exp_idx [$];
        logic [15:0] held_k;
        logic [1:0]  held_i;
        bit          hold = 0;
        bit          seen_done = 0;
        bit          rev = 0;
        int          cyc, stalls = 0, first = -1, stall_left = 3, popped = 0;
`ifdef SAES_KEY_REVERSE_EN
        rev = !enc;
`endif
        for (int i = 0; i < 3; i++) begin
            int r;
            r = rev ? 2 - i : i;
            exp_key.push_back(model_key(k, r));
            exp_idx.push_back(r[1:0]);
        end
        start     = 1'b1;
        key       = k;
        encrypt   = enc;
        key_ready = 1'b0;
        tick();
        cyc = 1;
        key = 16'($urandom);
        encrypt = ~enc;
        while (!seen_done && cyc < 60) begin
            if (glitch && cyc == 2) begin
                start = 1'b1;
                key   = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
            if (key_valid) begin
                if (first < 0) first = cyc;
                if (hold) begin
                    check("hold_key", round_key, held_k);
                    check("hold_idx", round_idx, held_i);
                end
                check("round_key", round_key, exp_key[0]);
                check("round_idx", round_idx, exp_idx[0]);
                check("done_early", done, 0);
                if (mode == 0) key_ready = 1'b1;
                else if (mode == 1) key_ready = ($urandom_range(0, 2) != 0);
                else if (popped == 1 && stall_left > 0) begin
                    key_ready = 1'b0;
                    stall_left--;
                end else key_ready = 1'b1;
                hold   = !key_ready;
                held_k = round_key;
                held_i = round_idx;
                if (key_ready) begin
                    void'(exp_key.pop_front());
                    void'(exp_idx.pop_front());
                    popped++;
                end else begin
                    stalls++;
                end
            end else if (done) begin
                seen_done = 1;
                check("done_cycle", cyc, 6 + stalls);
                check("first_latency", first, 3);
                check("keys_left", exp_key.size(), 0);
                check("busy_at_done", busy, 0);
                check("key_at_done", round_key, 0);
            end else begin
                check("idle_key", round_key, 0);
                check("busy_exp", busy, 1);
                key_ready = 1'($urandom);
            end
            if (!seen_done) begin
                tick();
                cyc++;
            end
        end
        start = 1'b0;
        if (!seen_done) check("timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, key_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_key"}, round_key, 0);
        check({tag, "_idx"}, round_idx, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        key       = 16'h0000;
        encrypt   = 1'b1;
        key_ready = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        check_reset_outputs("idle");

        run_seq(16'h4AF5, 1'b1, 0, 1'b0);
        run_seq(16'h0000, 1'b1, 0, 1'b0);
        run_seq(16'h4AF5, 1'b0, 0, 1'b0);
        run_seq(16'h4AF5, 1'b1, 2, 1'b0);
        tick();
        run_seq(16'h4AF5, 1'b1, 0, 1'b1);

        // Reset after K0 has been accepted.
        tick();
        start = 1'b1;
        key   = 16'h1234;
        tick();
        start     = 1'b0;
        key_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("pre_reset_idx", round_idx, 1);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        tick();
        run_seq(16'h1234, 1'b1, 0, 1'b0);

        for (int n = 0; n < 25; n++) begin
            run_seq(16'($urandom), 1'($urandom), 1, 1'($urandom));
            if ($urandom_range(0, 1) == 0) tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
